// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: Mini-SRC opcodes, FSM states and instruction classes for the control sequencer.
package control_sequencer_pkg;
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    typedef enum logic [3:0] {
        C_ILL, C_NOP, C_HALT, C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_UNARY, C_MULDIV, C_MFHI, C_MFLO
    } iclass_t;

    // Immediate forms run the ALU with the code of their register-form counterpart.
    function automatic logic [4:0] imm_alu_op(input logic [4:0] opc);
        return opc == OP_ADDI ? OP_ADD : opc == OP_ANDI ? OP_AND : OP_OR;
    endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: IR/memory/stop inputs and datapath strobes of the control sequencer.
// HIout/LOout exist only when MULDIV_EN is defined.
interface control_sequencer_if #(
    parameter int IR_W    = 32,
    parameter int ALUOP_W = 5
);
    logic [IR_W-1:0]    ir;
    logic               mem_ready, stop;
    logic               PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin;
    logic               Gra, Grb, Grc, Rin, Rout, BAout;
    logic               Yin, Zin, Zlowout, Zhighout, Cout, HIin, LOin;
    logic [ALUOP_W-1:0] alu_op;
    logic               run, illegal;
`ifdef MULDIV_EN
    logic               HIout, LOout;
`endif

    modport master (
        output ir, mem_ready, stop,
`ifdef MULDIV_EN
        input  HIout, LOout,
`endif
        input  PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Yin, Zin, Zlowout, Zhighout, Cout, HIin, LOin,
        input  alu_op, run, illegal
    );

    modport slave (
        input  ir, mem_ready, stop,
`ifdef MULDIV_EN
        output HIout, LOout,
`endif
        output PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Yin, Zin, Zlowout, Zhighout, Cout, HIin, LOin,
        output alu_op, run, illegal
    );
endinterface

// File: rtl/control_sequencer_opcode_class_dec.sv
// opcode_class_dec: maps an opcode onto the instruction class that selects its execute sequence (MULDIV_EN adds mul/div/mfhi/mflo).
module opcode_class_dec
    import control_sequencer_pkg::*;
(
    input  logic [4:0] opc_i,
    output iclass_t    cls_o
);
    // Anything not listed (branches, I/O, spare codes, mul/div/mfhi/mflo when disabled) is illegal.
    always_comb begin
        case (opc_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls_o = C_ALU;
            OP_ADDI, OP_ANDI, OP_ORI: cls_o = C_IMM;
            OP_LDI:                   cls_o = C_LDI;
            OP_LD:                    cls_o = C_LD;
            OP_ST:                    cls_o = C_ST;
            OP_NEG, OP_NOT:           cls_o = C_UNARY;
            OP_NOP:                   cls_o = C_NOP;
            OP_HALT:                  cls_o = C_HALT;
`ifdef MULDIV_EN
            OP_MUL, OP_DIV:           cls_o = C_MULDIV;
            OP_MFHI:                  cls_o = C_MFHI;
            OP_MFLO:                  cls_o = C_MFLO;
`endif
            default:                  cls_o = C_ILL;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Mini-SRC Moore control unit stepping fetch T0-T2 and execute T3-T7 per opcode.
// Define MULDIV_EN to add the mul/div/mfhi/mflo sequences and the HIout/LOout strobes.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int IR_W    = 32,
    parameter int OPC_W   = 5,
    parameter int ALUOP_W = 5
) (
    input logic                clk,
    input logic                clr_n,
    control_sequencer_if.slave bus
);
    state_t           state_q, state_d;
    logic             run_q, wait_q, wait_d, stop_q, stop_d, end_instr;
    logic [OPC_W-1:0] opc;
    iclass_t          cls;
    logic             unused_ir;

    assign opc       = bus.ir[IR_W-1 -: OPC_W];
    assign unused_ir = ^bus.ir[IR_W-OPC_W-1:0];

    opcode_class_dec u_dec (.opc_i(opc), .cls_o(cls));

    // State and flags; run_q stays low for one cycle after reset so the first T0 is fully visible.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= T0;
            run_q   <= 1'b0;
            wait_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            wait_q  <= wait_d;
            stop_q  <= stop_d;
        end
    end

    // Next state: hold in memory waits, branch on class, and divert to HALT at a pending stop on instruction boundaries.
    always_comb begin
        state_d   = state_q;
        wait_d    = 1'b0;
        stop_d    = stop_q | bus.stop;
        end_instr = !run_q;
        case (state_q)
            T0: state_d = T1;
            T1: begin
                state_d = bus.mem_ready ? T2 : T1;
                wait_d  = !bus.mem_ready;
            end
            T2: state_d = T3;
            T3: begin
                state_d   = cls == C_HALT ? HALT : T4;
                end_instr = cls inside {C_NOP, C_ILL, C_MFHI, C_MFLO};
            end
            T4: begin
                state_d   = T5;
                end_instr = cls == C_UNARY;
            end
            T5: begin
                state_d   = T6;
                end_instr = cls inside {C_ALU, C_IMM, C_LDI};
            end
            T6: begin
                state_d   = (cls == C_LD && !bus.mem_ready) ? T6 : T7;
                end_instr = cls == C_MULDIV;
            end
            T7: end_instr = cls != C_ST || bus.mem_ready;
            default: state_d = HALT;
        endcase
        if (end_instr) begin
            state_d = stop_d ? HALT : T0;
            stop_d  = 1'b0;
        end
    end

    // Moore output decode from state and opcode class; everything stays low before run_q and in HALT.
    always_comb begin
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.PCin     = 1'b0;
        bus.Read     = 1'b0;
        bus.Write    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.BAout    = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Cout     = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
`ifdef MULDIV_EN
        bus.HIout    = 1'b0;
        bus.LOout    = 1'b0;
`endif
        bus.alu_op   = '0;
        bus.illegal  = 1'b0;
        bus.run      = run_q && state_q != HALT;
        if (run_q) begin
            case (state_q)
                T0: begin
                    bus.PCout = 1'b1;
                    bus.MARin = 1'b1;
                    bus.IncPC = 1'b1;
                    bus.Zin   = 1'b1;
                end
                T1: begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = !wait_q;
                    bus.Read    = 1'b1;
                    bus.MDRin   = 1'b1;
                end
                T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                end
                T3: case (cls)
                    C_ALU, C_IMM: begin
                        bus.Grb  = 1'b1;
                        bus.Rout = 1'b1;
                        bus.Yin  = 1'b1;
                    end
                    C_LDI, C_LD, C_ST: begin
                        bus.Grb   = 1'b1;
                        bus.BAout = 1'b1;
                        bus.Yin   = 1'b1;
                    end
                    C_UNARY: begin
                        bus.Grb    = 1'b1;
                        bus.Rout   = 1'b1;
                        bus.Zin    = 1'b1;
                        bus.alu_op = ALUOP_W'(opc);
                    end
                    C_ILL: bus.illegal = 1'b1;
`ifdef MULDIV_EN
                    C_MULDIV: begin
                        bus.Gra  = 1'b1;
                        bus.Rout = 1'b1;
                        bus.Yin  = 1'b1;
                    end
                    C_MFHI: begin
                        bus.HIout = 1'b1;
                        bus.Gra   = 1'b1;
                        bus.Rin   = 1'b1;
                    end
                    C_MFLO: begin
                        bus.LOout = 1'b1;
                        bus.Gra   = 1'b1;
                        bus.Rin   = 1'b1;
                    end
`endif
                    default: ;
                endcase
                T4: case (cls)
                    C_ALU: begin
                        bus.Grc    = 1'b1;
                        bus.Rout   = 1'b1;
                        bus.Zin    = 1'b1;
                        bus.alu_op = ALUOP_W'(opc);
                    end
                    C_IMM: begin
                        bus.Cout   = 1'b1;
                        bus.Zin    = 1'b1;
                        bus.alu_op = ALUOP_W'(imm_alu_op(opc));
                    end
                    C_LDI, C_LD, C_ST: begin
                        bus.Cout   = 1'b1;
                        bus.Zin    = 1'b1;
                        bus.alu_op = ALUOP_W'(OP_ADD);
                    end
                    C_UNARY: begin
                        bus.Zlowout = 1'b1;
                        bus.Gra     = 1'b1;
                        bus.Rin     = 1'b1;
                    end
`ifdef MULDIV_EN
                    C_MULDIV: begin
                        bus.Grb    = 1'b1;
                        bus.Rout   = 1'b1;
                        bus.Zin    = 1'b1;
                        bus.alu_op = ALUOP_W'(opc);
                    end
`endif
                    default: ;
                endcase
                T5: case (cls)
                    C_ALU, C_IMM, C_LDI: begin
                        bus.Zlowout = 1'b1;
                        bus.Gra     = 1'b1;
                        bus.Rin     = 1'b1;
                    end
                    C_LD, C_ST: begin
                        bus.Zlowout = 1'b1;
                        bus.MARin   = 1'b1;
                    end
`ifdef MULDIV_EN
                    C_MULDIV: begin
                        bus.Zlowout = 1'b1;
                        bus.LOin    = 1'b1;
                    end
`endif
                    default: ;
                endcase
                T6: case (cls)
                    C_LD: begin
                        bus.Read  = 1'b1;
                        bus.MDRin = 1'b1;
                    end
                    C_ST: begin
                        bus.Gra   = 1'b1;
                        bus.Rout  = 1'b1;
                        bus.MDRin = 1'b1;
                    end
`ifdef MULDIV_EN
                    C_MULDIV: begin
                        bus.Zhighout = 1'b1;
                        bus.HIin     = 1'b1;
                    end
`endif
                    default: ;
                endcase
                T7: case (cls)
                    C_LD: begin
                        bus.MDRout = 1'b1;
                        bus.Gra    = 1'b1;
                        bus.Rin    = 1'b1;
                    end
                    C_ST: begin
                        bus.MDRout = 1'b1;
                        bus.Write  = 1'b1;
                    end
                    default: ;
                endcase
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random instruction streams against a per-instruction step model.
module tb_control_sequencer;
    localparam logic [4:0] LD = 5'd0, LDI = 5'd1, ST = 5'd2, ADD = 5'd3, AND = 5'd5, OR = 5'd6, ROL = 5'd11;
    localparam logic [4:0] ADDI = 5'd12, ANDI = 5'd13, ORI = 5'd14, MUL = 5'd15, DIV = 5'd16;
    localparam logic [4:0] NEG = 5'd17, NOT = 5'd18, MFHI = 5'd24, MFLO = 5'd25, NOP = 5'd26, HALT = 5'd27;

    localparam logic [23:0] S_PCOUT = 24'd1 << 0,  S_MARIN = 24'd1 << 1,  S_INCPC = 24'd1 << 2;
    localparam logic [23:0] S_PCIN  = 24'd1 << 3,  S_READ  = 24'd1 << 4,  S_WRITE = 24'd1 << 5;
    localparam logic [23:0] S_MDRIN = 24'd1 << 6,  S_MDROUT = 24'd1 << 7, S_IRIN  = 24'd1 << 8;
    localparam logic [23:0] S_GRA   = 24'd1 << 9,  S_GRB   = 24'd1 << 10, S_GRC   = 24'd1 << 11;
    localparam logic [23:0] S_RIN   = 24'd1 << 12, S_ROUT  = 24'd1 << 13, S_BAOUT = 24'd1 << 14;
    localparam logic [23:0] S_YIN   = 24'd1 << 15, S_ZIN   = 24'd1 << 16, S_ZLO   = 24'd1 << 17;
    localparam logic [23:0] S_ZHI   = 24'd1 << 18, S_COUT  = 24'd1 << 19, S_HIIN  = 24'd1 << 20;
    localparam logic [23:0] S_LOIN  = 24'd1 << 21, S_HIOUT = 24'd1 << 22, S_LOOUT = 24'd1 << 23;

    typedef struct {
        logic [23:0] s;
        logic [23:0] once;
        logic [4:0]  alu;
        bit          av;
        bit          ill;
        int          hold;
    } step_t;

    logic  clk = 1'b0;
    logic  clr_n;
    int    checks = 0;
    int    errors = 0;
    step_t q[$];

    control_sequencer_if #(.IR_W(32), .ALUOP_W(5)) bus ();

    control_sequencer dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [23:0] strobes();
        logic [23:0] v;
        v = {2'b00, bus.LOin, bus.HIin, bus.Cout, bus.Zhighout, bus.Zlowout, bus.Zin, bus.Yin, bus.BAout,
             bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.IRin, bus.MDRout, bus.MDRin, bus.Write,
             bus.Read, bus.PCin, bus.IncPC, bus.MARin, bus.PCout};
`ifdef MULDIV_EN
        v[22] = bus.HIout;
        v[23] = bus.LOout;
`endif
        return v;
    endfunction

    function automatic step_t mk(input logic [23:0] s, input logic [4:0] alu = 5'd0, input bit av = 1'b0,
                                 input int hold = -1, input bit ill = 1'b0);
        step_t t;
        t.s = s;
        t.once = '0;
        t.alu = alu;
        t.av = av;
        t.ill = ill;
        t.hold = hold;
        return t;
    endfunction

    // Expected cycle steps of one instruction; hold >= 0 marks a memory wait of that many not-ready cycles.
    function automatic void build(input logic [4:0] opc, input int fw, input int mw);
        step_t t;
        q.delete();
        q.push_back(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN));
        t = mk(S_ZLO | S_PCIN | S_READ | S_MDRIN, 5'd0, 1'b0, fw);
        t.once = S_PCIN;
        q.push_back(t);
        q.push_back(mk(S_MDROUT | S_IRIN));
        if (opc inside {[ADD:ROL]}) begin
            q.push_back(mk(S_GRB | S_ROUT | S_YIN));
            q.push_back(mk(S_GRC | S_ROUT | S_ZIN, opc, 1'b1));
            q.push_back(mk(S_ZLO | S_GRA | S_RIN));
        end else if (opc inside {ADDI, ANDI, ORI}) begin
            q.push_back(mk(S_GRB | S_ROUT | S_YIN));
            q.push_back(mk(S_COUT | S_ZIN, opc == ADDI ? ADD : opc == ANDI ? AND : OR, 1'b1));
            q.push_back(mk(S_ZLO | S_GRA | S_RIN));
        end else if (opc inside {LDI, LD, ST}) begin
            q.push_back(mk(S_GRB | S_BAOUT | S_YIN));
            q.push_back(mk(S_COUT | S_ZIN, ADD, 1'b1));
            if (opc == LDI) begin
                q.push_back(mk(S_ZLO | S_GRA | S_RIN));
            end else if (opc == LD) begin
                q.push_back(mk(S_ZLO | S_MARIN));
                q.push_back(mk(S_READ | S_MDRIN, 5'd0, 1'b0, mw));
                q.push_back(mk(S_MDROUT | S_GRA | S_RIN));
            end else begin
                q.push_back(mk(S_ZLO | S_MARIN));
                q.push_back(mk(S_GRA | S_ROUT | S_MDRIN));
                q.push_back(mk(S_MDROUT | S_WRITE, 5'd0, 1'b0, mw));
            end
        end else if (opc inside {NEG, NOT}) begin
            q.push_back(mk(S_GRB | S_ROUT | S_ZIN, opc, 1'b1));
            q.push_back(mk(S_ZLO | S_GRA | S_RIN));
        end else if (opc == NOP || opc == HALT) begin
            q.push_back(mk('0));
        end
`ifdef MULDIV_EN
        else if (opc inside {MUL, DIV}) begin
            q.push_back(mk(S_GRA | S_ROUT | S_YIN));
            q.push_back(mk(S_GRB | S_ROUT | S_ZIN, opc, 1'b1));
            q.push_back(mk(S_ZLO | S_LOIN));
            q.push_back(mk(S_ZHI | S_HIIN));
        end else if (opc == MFHI) begin
            q.push_back(mk(S_HIOUT | S_GRA | S_RIN));
        end else if (opc == MFLO) begin
            q.push_back(mk(S_LOOUT | S_GRA | S_RIN));
        end
`endif
        else begin
            q.push_back(mk('0, 5'd0, 1'b0, -1, 1'b1));
        end
    endfunction

    task automatic chk(input logic [23:0] s, input logic [4:0] alu, input bit av, input bit ill,
                       input bit run, input string tag);
        logic [30:0] obs, exp, msk;
        obs = {bus.run, bus.illegal, bus.alu_op, strobes()};
        exp = {run, ill, alu, s};
        msk = {2'b11, av ? 5'h1f : 5'h00, 24'hffffff};
        checks++;
        assert ((obs & msk) === (exp & msk)) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs & msk, exp & msk);
        end
    endtask

    // Async reset mid-cycle, outputs checked low at once, released on a falling edge.
    task automatic do_reset();
        #1 clr_n = 1'b0;
        bus.stop = 1'b0;
        #1 chk('0, 5'd0, 1'b1, 1'b0, 1'b0, "rst_async");
        repeat (2) @(negedge clk);
        chk('0, 5'd0, 1'b1, 1'b0, 1'b0, "rst_hold");
        clr_n = 1'b1;
        #1 chk('0, 5'd0, 1'b1, 1'b0, 1'b0, "rst_release");
    endtask

    task automatic halt_chk(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk('0, 5'd0, 1'b1, 1'b0, 1'b0, tag);
            bus.mem_ready = 1'($urandom);
        end
    endtask

    // Walk one instruction cycle by cycle; stop is raised from cycle stop_at, reset hits at cycle abort_at.
    task automatic run_instr(input logic [31:0] ir_v, input int fw, input int mw, input int stop_at,
                             input int abort_at);
        int n;
        int h;
        logic [4:0] opc;
        n = 0;
        opc = ir_v[31:27];
        build(opc, fw, mw);
        foreach (q[k]) begin
            h = q[k].hold < 0 ? 0 : q[k].hold;
            for (int i = 0; i <= h; i++) begin
                @(negedge clk);
                chk(i > 0 ? q[k].s & ~q[k].once : q[k].s, q[k].alu, q[k].av, q[k].ill, 1'b1,
                    $sformatf("op%0d step%0d cyc%0d", opc, k, n));
                if (n == 0) bus.ir = ir_v;
                if (stop_at >= 0 && n >= stop_at) bus.stop = 1'b1;
                bus.mem_ready = q[k].hold < 0 ? 1'($urandom) : (i == h);
                if (n == abort_at) begin
                    do_reset();
                    return;
                end
                n++;
            end
        end
    endtask

    initial begin
        logic [4:0] opc;
        clr_n = 1'b0;
        bus.ir = '0;
        bus.mem_ready = 1'b0;
        bus.stop = 1'b0;
        do_reset();
        run_instr(32'h18918000, 0, 0, -1, -1);
        run_instr(32'h00900010, 0, 3, -1, -1);
        run_instr(32'h10900010, 1, 2, -1, -1);
        run_instr(32'h80000000, 0, 0, -1, -1);
        run_instr(32'h0C900005, 2, 0, -1, -1);
        run_instr(32'h00900010, 0, 5, -1, 7);
        run_instr(32'h18918000, 0, 0, 4, -1);
        halt_chk(3, "stop_halt");
        do_reset();
        run_instr(32'hD8000000, 0, 0, -1, -1);
        halt_chk(22, "halt");
        do_reset();
        for (int i = 0; i < 40; i++) begin
            opc = 5'($urandom_range(0, 31));
            while (opc == HALT) opc = 5'($urandom_range(0, 31));
            run_instr({opc, 27'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), -1, -1);
        end
        run_instr(32'hD8000000, 1, 0, 3, -1);
        halt_chk(4, "halt_and_stop");
        do_reset();
        run_instr(32'h68800001, 0, 0, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
